// File: rtl/latch_cond_pkg.sv
// Shared types and defaults for the latch input conditioner.
// Optional edge pulses are enabled with the LATCH_COND_EDGE_PULSE_EN macro.
package latch_cond_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } deb_state_t;

   localparam int DEF_STABLE_CNT = 100000;
   localparam int DEF_CNT_W      = 17;

endpackage

// File: rtl/latch_input_conditioner_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, hold-time FSM/counter, registered clean output.
// With LATCH_COND_EDGE_PULSE_EN defined, also emits registered rise (and optionally fall) pulses.
module debounce_channel
   import latch_cond_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = DEF_CNT_W
`ifdef LATCH_COND_EDGE_PULSE_EN
   ,
   parameter int PULSE_W    = 1
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
`ifdef LATCH_COND_EDGE_PULSE_EN
   ,
   output logic [PULSE_W-1:0] pulse
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

   generate
      if (STABLE_CNT < 2) begin : g_bad_stable_cnt
         $error("debounce_channel: STABLE_CNT must be at least 2");
      end
      if ((STABLE_CNT - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
         $error("debounce_channel: CNT_W too narrow to hold STABLE_CNT-1");
      end
   endgenerate

   logic             s1;
   logic             s2;
   deb_state_t       state;
   deb_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             clean_nxt;

   // The counter only advances while checking, and resets on every state entry,
   // so it saturates at CNT_MAX and cannot wrap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         STABLE_LO: begin
            if (s2) begin
               state_nxt = CHK_HI;
               cnt_nxt   = '0;
            end
         end
         CHK_HI: begin
            if (!s2) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = STABLE_HI;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!s2) begin
               state_nxt = CHK_LO;
               cnt_nxt   = '0;
            end
         end
         CHK_LO: begin
            if (s2) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = STABLE_LO;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
         end
      endcase
      clean_nxt = (state_nxt == STABLE_HI) || (state_nxt == CHK_LO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= STABLE_LO;
         cnt   <= '0;
         clean <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         clean <= clean_nxt;
      end
   end

`ifdef LATCH_COND_EDGE_PULSE_EN
   // Pulses are registered on the same edge as clean, so they coincide with
   // the first cycle of the new clean level. MSB is rise; bit 0 is fall when PULSE_W==2.
   generate
      if (PULSE_W == 2) begin : g_rise_fall
         always_ff @(posedge clk) begin
            if (rst) begin
               pulse <= '0;
            end else begin
               pulse <= {clean_nxt & ~clean, ~clean_nxt & clean};
            end
         end
      end else begin : g_rise
         always_ff @(posedge clk) begin
            if (rst) begin
               pulse <= '0;
            end else begin
               pulse <= PULSE_W'(clean_nxt & ~clean);
            end
         end
      end
   endgenerate
`endif

endmodule

// File: rtl/latch_input_conditioner.sv
// Debounces the data and enable switches feeding a downstream D latch.
// Defining LATCH_COND_EDGE_PULSE_EN adds the d_rise, e_rise and e_fall pulse outputs.
module latch_input_conditioner
   import latch_cond_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic d_raw,
   input  logic e_raw,
   output logic d_clean,
   output logic e_clean
`ifdef LATCH_COND_EDGE_PULSE_EN
   ,
   output logic d_rise,
   output logic e_rise,
   output logic e_fall
`endif
);

   debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
`ifdef LATCH_COND_EDGE_PULSE_EN
      ,
      .PULSE_W    (1)
`endif
   ) u_d (
      .clk   (clk),
      .rst   (rst),
      .raw   (d_raw),
      .clean (d_clean)
`ifdef LATCH_COND_EDGE_PULSE_EN
      ,
      .pulse (d_rise)
`endif
   );

   debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
`ifdef LATCH_COND_EDGE_PULSE_EN
      ,
      .PULSE_W    (2)
`endif
   ) u_e (
      .clk   (clk),
      .rst   (rst),
      .raw   (e_raw),
      .clean (e_clean)
`ifdef LATCH_COND_EDGE_PULSE_EN
      ,
      .pulse ({e_rise, e_fall})
`endif
   );

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Directed bench for latch_input_conditioner with STABLE_CNT=4, CNT_W=3.
// Pulse outputs are checked only when LATCH_COND_EDGE_PULSE_EN is defined.
module tb_latch_input_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic d_raw;
   logic e_raw;
   logic d_clean;
   logic e_clean;
`ifdef LATCH_COND_EDGE_PULSE_EN
   logic d_rise;
   logic e_rise;
   logic e_fall;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   latch_input_conditioner #(
      .STABLE_CNT (4),
      .CNT_W      (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .d_raw   (d_raw),
      .e_raw   (e_raw),
      .d_clean (d_clean),
      .e_clean (e_clean)
`ifdef LATCH_COND_EDGE_PULSE_EN
      ,
      .d_rise  (d_rise),
      .e_rise  (e_rise),
      .e_fall  (e_fall)
`endif
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b want %b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      d_raw = 1'b0;
      e_raw = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_d_clean", d_clean, 1'b0);
      chk("rst_e_clean", e_clean, 1'b0);
`ifdef LATCH_COND_EDGE_PULSE_EN
      chk("rst_d_rise", d_rise, 1'b0);
      chk("rst_e_rise", e_rise, 1'b0);
      chk("rst_e_fall", e_fall, 1'b0);
`endif

      // d_raw=1 sampled from edge 0: clean rises after edge 6
      rst   = 1'b0;
      d_raw = 1'b1;
      for (int n = 0; n < 8; n++) begin
         tick();
         chk($sformatf("rise_d_clean_e%0d", n), d_clean, n >= 6);
         chk($sformatf("rise_e_idle_e%0d", n), e_clean, 1'b0);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("rise_d_rise_e%0d", n), d_rise, n == 6);
`endif
      end

      // 2-cycle low bounce while high is rejected
      for (int n = 0; n < 10; n++) begin
         d_raw = !(n == 0 || n == 1);
         tick();
         chk($sformatf("bounce_d_clean_%0d", n), d_clean, 1'b1);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("bounce_d_rise_%0d", n), d_rise, 1'b0);
`endif
      end

      // Held low after the bounce: full latency from STABLE_HI
      d_raw = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         chk($sformatf("fall_d_clean_e%0d", n), d_clean, n < 6);
      end

      // e at edge 0, d at edge 1: independent latencies
      do_reset();
      rst   = 1'b0;
      e_raw = 1'b1;
      for (int n = 0; n < 9; n++) begin
         tick();
         chk($sformatf("par_e_clean_e%0d", n), e_clean, n >= 6);
         chk($sformatf("par_d_clean_e%0d", n), d_clean, n >= 7);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("par_e_rise_e%0d", n), e_rise, n == 6);
         chk($sformatf("par_d_rise_e%0d", n), d_rise, n == 7);
`endif
         if (n == 0) d_raw = 1'b1;
      end

      // e falls 6 cycles after e_raw drops; d stays high
      e_raw = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         chk($sformatf("efall_e_clean_e%0d", n), e_clean, n < 6);
         chk($sformatf("efall_d_clean_e%0d", n), d_clean, 1'b1);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("efall_e_fall_e%0d", n), e_fall, n == 6);
         chk($sformatf("efall_e_rise_e%0d", n), e_rise, 1'b0);
`endif
      end

      // Reset mid-check at edge 4, released at edge 5
      do_reset();
      rst   = 1'b0;
      e_raw = 1'b1;
      for (int n = 0; n < 13; n++) begin
         tick();
         chk($sformatf("midrst_e_clean_e%0d", n), e_clean, n >= 11);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("midrst_e_rise_e%0d", n), e_rise, n == 11);
`endif
         if (n == 3) rst = 1'b1;
         if (n == 4) rst = 1'b0;
      end

      // 3-cycle high glitch (STABLE_CNT-1) on d is rejected
      for (int n = 0; n < 10; n++) begin
         d_raw = (n < 3);
         tick();
         chk($sformatf("glitch_d_clean_%0d", n), d_clean, 1'b0);
         chk($sformatf("glitch_e_clean_%0d", n), e_clean, 1'b1);
`ifdef LATCH_COND_EDGE_PULSE_EN
         chk($sformatf("glitch_d_rise_%0d", n), d_rise, 1'b0);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
